// File: rtl/rf_port_arbiter.sv
// Round-robin arbiter sharing the single register-file port between two requesters.
// Each operation takes one ACCESS cycle (port driven) and one RESP cycle (done pulse).
`timescale 1ns/1ps
module rf_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_load,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} stateT;

  stateT             stateReg;
  logic              lastReg;
  logic              ownerReg;
  logic              weReg;
  logic [ADDR_W-1:0] addrReg;
  logic [DATA_W-1:0] wdataReg;
  logic [DATA_W-1:0] rdata0Reg;
  logic [DATA_W-1:0] rdata1Reg;

  logic cand0, cand1, winValid, winSel;

  // In RESP the current owner is still holding req for the op just finished; mask it.
  always_comb begin
    cand0    = req0 && !(stateReg == RESP && !ownerReg);
    cand1    = req1 && !(stateReg == RESP && ownerReg);
    winValid = (stateReg == IDLE || stateReg == RESP) && (cand0 || cand1);
    winSel   = (cand0 && cand1) ? ~lastReg : cand1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stateReg  <= IDLE;
      lastReg   <= 1'b1;
      ownerReg  <= 1'b0;
      weReg     <= 1'b0;
      addrReg   <= '0;
      wdataReg  <= '0;
      rdata0Reg <= '0;
      rdata1Reg <= '0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (winValid) begin
            ownerReg <= winSel;
            weReg    <= winSel ? we1 : we0;
            addrReg  <= winSel ? addr1 : addr0;
            wdataReg <= winSel ? wdata1 : wdata0;
            stateReg <= ACCESS;
          end
        end
        ACCESS: begin
          if (!weReg) begin
            if (ownerReg) rdata1Reg <= rf_rdata;
            else          rdata0Reg <= rf_rdata;
          end
          stateReg <= RESP;
        end
        RESP: begin
          lastReg <= ownerReg;
          if (winValid) begin
            ownerReg <= winSel;
            weReg    <= winSel ? we1 : we0;
            addrReg  <= winSel ? addr1 : addr0;
            wdataReg <= winSel ? wdata1 : wdata0;
            stateReg <= ACCESS;
          end else begin
            stateReg <= IDLE;
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

  // Port outputs decode straight from the state register so a reset clears them at once.
  assign gnt0     = (stateReg == ACCESS) && !ownerReg;
  assign gnt1     = (stateReg == ACCESS) && ownerReg;
  assign done0    = (stateReg == RESP) && !ownerReg;
  assign done1    = (stateReg == RESP) && ownerReg;
  assign rf_load  = (stateReg == ACCESS) && weReg;
  assign rf_addr  = (stateReg == ACCESS) ? addrReg : '0;
  assign rf_wdata = (stateReg == ACCESS) ? wdataReg : '0;
  assign rdata0   = rdata0Reg;
  assign rdata1   = rdata1Reg;
  assign busy     = (stateReg != IDLE);

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Testbench for rf_port_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level register-file scoreboard.
`timescale 1ns/1ps
module tb_rf_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          reqV   [2];
  logic          cmdWe  [2];
  logic [AW-1:0] cmdAddr[2];
  logic [DW-1:0] cmdData[2];
  logic          gnt0, done0, gnt1, done1, rf_load, busy;
  logic [DW-1:0] rdata0, rdata1, rf_wdata, rf_rdata;
  logic [AW-1:0] rf_addr;

  // Environment register file, plus a preload path used only while the DUT is in reset
  logic [DW-1:0] rfMem [32];
  logic          pl;
  logic [AW-1:0] plAddr;
  logic [DW-1:0] plData;

  // Scoreboard state
  logic [DW-1:0] refMem [32];
  logic [DW-1:0] expR   [2];
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  assign rf_rdata = rfMem[rf_addr];
  always @(posedge CLK) begin
    if (pl) rfMem[plAddr] <= plData;
    else if (rf_load) rfMem[rf_addr] <= rf_wdata;
  end

  rf_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK(CLK), .RESET(RESET),
    .req0(reqV[0]), .we0(cmdWe[0]), .addr0(cmdAddr[0]), .wdata0(cmdData[0]),
    .gnt0(gnt0), .done0(done0), .rdata0(rdata0),
    .req1(reqV[1]), .we1(cmdWe[1]), .addr1(cmdAddr[1]), .wdata1(cmdData[1]),
    .gnt1(gnt1), .done1(done1), .rdata1(rdata1),
    .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_load(rf_load), .rf_rdata(rf_rdata),
    .busy(busy)
  );

  task automatic setCmd(input int r, input logic req, input logic we,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    reqV[r] = req; cmdWe[r] = we; cmdAddr[r] = a; cmdData[r] = d;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    pl = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge CLK);
      setCmd(0, 1'($urandom), 1'($urandom), AW'($urandom), $urandom);
      setCmd(1, 1'($urandom), 1'($urandom), AW'($urandom), $urandom);
      plAddr = AW'(i); plData = '0; refMem[i] = '0;
      #1;
      checks++;
      if ({gnt0, gnt1, done0, done1, rf_load, busy} !== 6'b0 || rf_addr !== '0 ||
          rf_wdata !== '0 || rdata0 !== '0 || rdata1 !== '0) begin
        errors++;
        $display("FAIL reset_outputs: gnt=%b%b done=%b%b load=%b busy=%b addr=%0d wdata=%h rdata0=%h rdata1=%h, required all 0",
                 gnt0, gnt1, done0, done1, rf_load, busy, rf_addr, rf_wdata, rdata0, rdata1);
      end
    end
    expR[0] = '0; expR[1] = '0;
    @(negedge CLK);
    pl = 1'b0;
    RESET = 1'b0;
    setCmd(0, 1'b1, 1'b0, 5'd1, '0);
    setCmd(1, 1'b1, 1'b0, 5'd2, '0);
    @(negedge CLK);
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL first_winner: gnt0=%b gnt1=%b, required gnt0=1 gnt1=0", gnt0, gnt1);
    end
    @(negedge CLK);
    checks++;
    if (done0 !== 1'b1 || rdata0 !== refMem[1]) begin
      errors++;
      $display("FAIL first_done: done0=%b rdata0=%h, required done0=1 rdata0=%h", done0, rdata0, refMem[1]);
    end
    reqV[0] = 1'b0; reqV[1] = 1'b0;
    @(negedge CLK);
    $display("reset test: first simultaneous request served to requester 0");
  endtask

  task automatic test_write();
    @(negedge CLK);
    setCmd(0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
    @(negedge CLK);
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || rf_load !== 1'b1 || rf_addr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_access: gnt0=%b gnt1=%b load=%b addr=%0d wdata=%h, required 1 0 1 5 deadbeef",
               gnt0, gnt1, rf_load, rf_addr, rf_wdata);
    end
    @(negedge CLK);
    checks++;
    if (done0 !== 1'b1 || done1 !== 1'b0 || rf_load !== 1'b0) begin
      errors++;
      $display("FAIL write_done: done0=%b done1=%b load=%b, required 1 0 0", done0, done1, rf_load);
    end
    refMem[5] = 32'hDEADBEEF;
    reqV[0] = 1'b0;
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || rfMem[5] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_commit: busy=%b reg5=%h, required busy=0 reg5=deadbeef", busy, rfMem[5]);
    end
    $display("op req0 write addr=5 data=deadbeef");
  endtask

  task automatic test_read();
    @(negedge CLK);
    setCmd(1, 1'b1, 1'b0, 5'd5, 32'h0);
    @(negedge CLK);
    checks++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || rf_load !== 1'b0 || rf_addr !== 5'd5) begin
      errors++;
      $display("FAIL read_access: gnt1=%b gnt0=%b load=%b addr=%0d, required 1 0 0 5", gnt1, gnt0, rf_load, rf_addr);
    end
    @(negedge CLK);
    checks++;
    if (done1 !== 1'b1 || rf_load !== 1'b0 || rdata1 !== 32'hDEADBEEF || rdata0 !== expR[0]) begin
      errors++;
      $display("FAIL read_done: done1=%b load=%b rdata1=%h rdata0=%h, required 1 0 deadbeef %h",
               done1, rf_load, rdata1, rdata0, expR[0]);
    end
    expR[1] = 32'hDEADBEEF;
    reqV[1] = 1'b0;
    @(negedge CLK);
    $display("op req1 read addr=5 data=%h", rdata1);
  endtask

  task automatic test_back_to_back();
    int  n[2];
    int  owner;
    n[0] = 0; n[1] = 0;
    owner = 0;
    @(negedge CLK);
    setCmd(0, 1'b1, 1'b1, 5'd8, $urandom);
    setCmd(1, 1'b1, 1'b0, 5'd8, '0);
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_busy: cycle %0d busy=%b, required 1", c, busy);
      end
      checks++;
      if (c % 2 == 0) begin
        if (gnt0 !== (owner == 0) || gnt1 !== (owner == 1)) begin
          errors++;
          $display("FAIL b2b_grant: cycle %0d gnt0=%b gnt1=%b, required owner %0d", c, gnt0, gnt1, owner);
        end
      end else begin
        if (done0 !== (owner == 0) || done1 !== (owner == 1)) begin
          errors++;
          $display("FAIL b2b_done: cycle %0d done0=%b done1=%b, required owner %0d", c, done0, done1, owner);
        end
        if (cmdWe[owner]) refMem[cmdAddr[owner]] = cmdData[owner];
        else              expR[owner] = refMem[cmdAddr[owner]];
        checks++;
        if (rdata0 !== expR[0] || rdata1 !== expR[1]) begin
          errors++;
          $display("FAIL b2b_rdata: rdata0=%h rdata1=%h, required %h %h", rdata0, rdata1, expR[0], expR[1]);
        end
        $display("op req%0d %s addr=%0d data=%h", owner, cmdWe[owner] ? "write" : "read",
                 cmdAddr[owner], cmdWe[owner] ? cmdData[owner] : expR[owner]);
        n[owner]++;
        if (n[owner] == 2) reqV[owner] = 1'b0;
        else setCmd(owner, 1'b1, ~cmdWe[owner], 5'd9, $urandom);
        owner = 1 - owner;
      end
    end
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset_mid_op();
    @(negedge CLK);
    setCmd(0, 1'b1, 1'b1, 5'd7, 32'h12345678);
    @(negedge CLK);
    checks++;
    if (rf_load !== 1'b1 || gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL abort_access: load=%b gnt0=%b, required 1 1", rf_load, gnt0);
    end
    #1 RESET = 1'b1;
    reqV[0] = 1'b0;
    #1;
    checks++;
    if (rf_load !== 1'b0 || gnt0 !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_immediate: load=%b gnt0=%b busy=%b, required 0 0 0", rf_load, gnt0, busy);
    end
    @(negedge CLK);
    RESET = 1'b0;
    expR[0] = '0; expR[1] = '0;
    checks++;
    if (rfMem[7] !== refMem[7]) begin
      errors++;
      $display("FAIL abort_commit: reg7=%h, required %h", rfMem[7], refMem[7]);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      checks++;
      if (busy !== 1'b0 || done0 !== 1'b0 || rdata0 !== '0) begin
        errors++;
        $display("FAIL abort_idle: busy=%b done0=%b rdata0=%h, required 0 0 0", busy, done0, rdata0);
      end
    end
    $display("op req0 write addr=7 aborted by reset");
  endtask

  task automatic test_late_drop();
    @(negedge CLK);
    setCmd(0, 1'b1, 1'b0, 5'd3, '0);
    @(negedge CLK);
    checks++;
    if (gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL drop_grant0: gnt0=%b, required 1", gnt0);
    end
    setCmd(1, 1'b1, 1'b0, 5'd4, '0);
    @(negedge CLK);
    checks++;
    if (done0 !== 1'b1 || rdata0 !== refMem[3]) begin
      errors++;
      $display("FAIL drop_done0: done0=%b rdata0=%h, required 1 %h", done0, rdata0, refMem[3]);
    end
    expR[0] = refMem[3];
    reqV[0] = 1'b0; reqV[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      checks++;
      if (gnt1 !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL drop_never_served: gnt1=%b busy=%b, required 0 0", gnt1, busy);
      end
    end
    $display("op req0 read addr=3, req1 dropped before capture");
  endtask

  task automatic test_random();
    logic pend[2], granted[2];
    int   waitC[2];
    logic g, d;
    pend[0] = 0; pend[1] = 0; granted[0] = 0; granted[1] = 0; waitC[0] = 0; waitC[1] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge CLK);
      for (int r = 0; r < 2; r++) begin
        d = (r == 0) ? done0 : done1;
        if (d) begin
          checks++;
          if (!granted[r]) begin
            errors++;
            $display("FAIL rnd_unexpected_done: req%0d done=1, required 0", r);
          end
          if (cmdWe[r]) refMem[cmdAddr[r]] = cmdData[r];
          else          expR[r] = refMem[cmdAddr[r]];
          $display("op req%0d %s addr=%0d data=%h", r, cmdWe[r] ? "write" : "read",
                   cmdAddr[r], cmdWe[r] ? cmdData[r] : expR[r]);
          granted[r] = 0; pend[r] = 0;
        end else if (granted[r]) begin
          checks++; errors++;
          $display("FAIL rnd_missing_done: req%0d done=0, required 1", r);
          granted[r] = 0; pend[r] = 0;
        end
      end
      checks++;
      if ((gnt0 && gnt1) || (done0 && done1)) begin
        errors++;
        $display("FAIL rnd_exclusive: gnt=%b%b done=%b%b, required at most one each", gnt0, gnt1, done0, done1);
      end
      for (int r = 0; r < 2; r++) begin
        g = (r == 0) ? gnt0 : gnt1;
        if (g) begin
          checks++;
          if (!pend[r] || rf_addr !== cmdAddr[r] || rf_load !== cmdWe[r] || rf_wdata !== cmdData[r]) begin
            errors++;
            $display("FAIL rnd_access: req%0d pend=%b addr=%0d load=%b wdata=%h, required 1 %0d %b %h",
                     r, pend[r], rf_addr, rf_load, rf_wdata, cmdAddr[r], cmdWe[r], cmdData[r]);
          end
          granted[r] = 1; waitC[r] = 0;
        end
      end
      if (!(gnt0 || gnt1)) begin
        checks++;
        if (rf_load !== 1'b0 || rf_addr !== '0 || rf_wdata !== '0) begin
          errors++;
          $display("FAIL rnd_port_idle: load=%b addr=%0d wdata=%h, required 0 0 0", rf_load, rf_addr, rf_wdata);
        end
      end
      checks++;
      if (busy !== (gnt0 | gnt1 | done0 | done1)) begin
        errors++;
        $display("FAIL rnd_busy: busy=%b, required %b", busy, gnt0 | gnt1 | done0 | done1);
      end
      checks++;
      if (rdata0 !== expR[0] || rdata1 !== expR[1]) begin
        errors++;
        $display("FAIL rnd_rdata: rdata0=%h rdata1=%h, required %h %h", rdata0, rdata1, expR[0], expR[1]);
      end
      for (int r = 0; r < 2; r++) begin
        if (pend[r] && !granted[r]) begin
          waitC[r]++;
          if (waitC[r] > 3) begin
            checks++; errors++;
            $display("FAIL rnd_starve: req%0d waited %0d cycles, required at most 3", r, waitC[r]);
            waitC[r] = 0;
          end
        end
        if (!pend[r]) begin
          if ($urandom_range(0, 2) == 0) begin
            setCmd(r, 1'b1, 1'($urandom), AW'($urandom_range(0, 7)), $urandom);
            pend[r] = 1; waitC[r] = 0;
          end else begin
            reqV[r] = 1'b0;
          end
        end
      end
    end
    // Let outstanding ops drain before comparing the whole register file
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      for (int r = 0; r < 2; r++) begin
        d = (r == 0) ? done0 : done1;
        if (d && cmdWe[r]) refMem[cmdAddr[r]] = cmdData[r];
        if (d || !pend[r]) begin reqV[r] = 1'b0; pend[r] = 0; end
      end
    end
    checks++;
    if (rfMem != refMem) begin
      errors++;
      $display("FAIL rnd_rf_contents: register file differs from scoreboard (reg8 %h vs %h)", rfMem[8], refMem[8]);
    end
  endtask

  initial begin
    RESET = 1'b1;
    pl = 1'b0; plAddr = '0; plData = '0;
    for (int r = 0; r < 2; r++) begin
      reqV[r] = 1'b0; cmdWe[r] = 1'b0; cmdAddr[r] = '0; cmdData[r] = '0; expR[r] = '0;
    end
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid_op();
    test_late_drop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
